// File: rtl/ble_cmd_scheduler.sv
// ble_cmd_scheduler: queues 16-bit Knight commands and issues them one at a time to the
// RemoteComm transmitter. After each command it waits for the 8-bit response and compares
// it against ACK_VAL.
// Optional macro BLE_RETRY_EN: a failed command is resent up to MAX_RETRY times before
// the block enters ERROR.
module ble_cmd_scheduler #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned TIMEOUT_CLKS = 10_000_000,
    parameter logic [7:0]  ACK_VAL      = 8'hA5,
    parameter int unsigned MAX_RETRY    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [15:0]              push_cmd,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [15:0]              cmd,
    output logic                     send_cmd,
    input  logic                     cmd_sent,
    input  logic                     resp_rdy,
    input  logic [7:0]               resp,
    output logic                     clr_rx_rdy,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    input  logic                     clr_err,
    input  logic                     abort
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
    localparam logic [AW:0]   FullLevel = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TmoLast   = TW'(TIMEOUT_CLKS - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must be at least 2");
    end
    if (MAX_RETRY > 15) begin : g_bad_retry
        $error("MAX_RETRY must fit the 4-bit retry counter");
    end

    typedef enum logic [2:0] {
        StIdle, StLoad, StSend, StWaitSent, StWaitResp, StCheck, StError
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q;
    logic            ovf_q;
    logic [15:0]     cmd_q;
    logic [7:0]      resp_q;
    logic [1:0]      err_code_q, err_code_d;
    logic [TW-1:0]   tmo_q, tmo_d, tmo_inc;
    logic            pop, load_cmd, latch_resp, fail;
    logic [1:0]      fail_code;
    logic            push_ok, ovf_set;

    assign full     = (level_q == FullLevel);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign cmd      = cmd_q;
    assign err_code = err_code_q;
    assign busy     = (state_q != StIdle) && (state_q != StError);
    assign err      = (state_q == StError);
    assign tmo_inc  = tmo_q + 1'b1;

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push_ok = push && !abort && (!full || pop);
    assign ovf_set = push && !abort && full && !pop;

`ifdef BLE_RETRY_EN
    localparam logic [3:0] RetryMax = 4'(MAX_RETRY);
    logic [3:0] retry_q, retry_d;

    // Retry counter for the command currently held in cmd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retry_q <= '0;
        else     retry_q <= retry_d;
    end
`endif

    // FIFO pointers and occupancy; abort flushes the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      level_q <= level_q + 1'b1;
            else if (!push_ok && pop) level_q <= level_q - 1'b1;
        end
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_cmd;
    end

    // Sticky overflow flag; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ovf_q <= 1'b0;
        else if (ovf_set) ovf_q <= 1'b1;
        else if (clr_err) ovf_q <= 1'b0;
    end

    // FSM state, timeout counter and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            err_code_q <= 2'b00;
            tmo_q      <= '0;
            cmd_q      <= 16'h0000;
            resp_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            tmo_q      <= tmo_d;
            if (load_cmd)   cmd_q  <= mem[rd_ptr_q];
            if (latch_resp) resp_q <= resp;
        end
    end

    // Next-state logic and handshake pulses; abort overrides every state.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        tmo_d      = tmo_q;
        pop        = 1'b0;
        load_cmd   = 1'b0;
        latch_resp = 1'b0;
        fail       = 1'b0;
        fail_code  = 2'b00;
        send_cmd   = 1'b0;
        clr_rx_rdy = 1'b0;
        done       = 1'b0;
`ifdef BLE_RETRY_EN
        retry_d    = retry_q;
`endif
        if (abort) begin
            state_d    = StIdle;
            clr_rx_rdy = (state_q == StWaitResp) || (state_q == StCheck);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) state_d = StLoad;
                end
                StLoad: begin
                    pop      = !empty;
                    load_cmd = 1'b1;
                    state_d  = StSend;
`ifdef BLE_RETRY_EN
                    retry_d  = '0;
`endif
                end
                StSend: begin
                    send_cmd = 1'b1;
                    tmo_d    = '0;
                    state_d  = StWaitSent;
                end
                StWaitSent: begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TmoLast) begin
                        fail      = 1'b1;
                        fail_code = 2'b10;
                    end else if (cmd_sent) begin
                        state_d = StWaitResp;
                    end
                end
                StWaitResp: begin
                    tmo_d = tmo_inc;
                    // A response arriving on the last allowed cycle still counts.
                    if (resp_rdy) begin
                        latch_resp = 1'b1;
                        state_d    = StCheck;
                    end else if (tmo_inc == TmoLast) begin
                        fail      = 1'b1;
                        fail_code = 2'b10;
                    end
                end
                StCheck: begin
                    clr_rx_rdy = 1'b1;
                    if (resp_q == ACK_VAL) begin
                        done    = empty;
                        state_d = empty ? StIdle : StLoad;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                    end
                end
                StError: begin
                    if (clr_err) begin
                        err_code_d = 2'b00;
                        state_d    = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (fail) begin
`ifdef BLE_RETRY_EN
                if (retry_q < RetryMax) begin
                    retry_d = retry_q + 1'b1;
                    state_d = StSend;
                end else begin
                    err_code_d = fail_code;
                    state_d    = StError;
                end
`else
                err_code_d = fail_code;
                state_d    = StError;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ble_cmd_scheduler.sv
// Self-checking bench for ble_cmd_scheduler: a per-cycle vector table for single and
// back-to-back commands, then directed sequences for overflow, bad response, timeout,
// abort and asynchronous reset.
module tb_ble_cmd_scheduler;

    logic        clk, rst, push, cmd_sent, resp_rdy, clr_err, abort;
    logic [15:0] push_cmd, cmd;
    logic [7:0]  resp;
    logic        full, empty, ovf, send_cmd, clr_rx_rdy, busy, done, err;
    logic [3:0]  level;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;

    ble_cmd_scheduler #(
        .DEPTH       (8),
        .TIMEOUT_CLKS(1000),
        .ACK_VAL     (8'hA5),
        .MAX_RETRY   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_cmd  (push_cmd),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .ovf       (ovf),
        .cmd       (cmd),
        .send_cmd  (send_cmd),
        .cmd_sent  (cmd_sent),
        .resp_rdy  (resp_rdy),
        .resp      (resp),
        .clr_rx_rdy(clr_rx_rdy),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .clr_err   (clr_err),
        .abort     (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

`ifdef BLE_RETRY_EN
    localparam int Tries = 3;
`else
    localparam int Tries = 1;
`endif

    typedef struct {
        logic        push;
        logic [15:0] pcmd;
        logic        csent;
        logic        rrdy;
        logic [7:0]  rsp;
        logic        x_send;
        logic        x_clr;
        logic        x_done;
        logic        x_busy;
        logic        x_empty;
        logic [3:0]  x_level;
        logic [15:0] x_cmd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic p, logic [15:0] pc, logic cs, logic rr, logic [7:0] rs,
                                logic s, logic c, logic d, logic b, logic e, logic [3:0] l,
                                logic [15:0] cm);
        vec_t v;
        v.push = p;  v.pcmd = pc; v.csent = cs; v.rrdy = rr; v.rsp = rs;
        v.x_send = s; v.x_clr = c; v.x_done = d; v.x_busy = b; v.x_empty = e;
        v.x_level = l; v.x_cmd = cm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // {busy, send_cmd, clr_rx_rdy, done, err, err_code, ovf, full, empty, level, cmd}
    function automatic logic [31:0] snap();
        return {2'b00, busy, send_cmd, clr_rx_rdy, done, err, err_code, ovf, full, empty,
                level, cmd};
    endfunction

    localparam logic [31:0] RstSnap = 32'h0010_0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the send_cmd pulse and checks the command presented with it.
    task automatic wait_send(input logic [15:0] exp_cmd, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!send_cmd && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_send_seen"}, 32'(send_cmd), 32'd1);
        check({name, "_cmd"}, 32'(cmd), 32'(exp_cmd));
    endtask

    // Plays RemoteComm: cmd_sent, then a response byte held until the CHECK cycle.
    task automatic respond(input logic [7:0] r);
        tick(); cmd_sent = 1'b1;
        tick(); cmd_sent = 1'b0; resp_rdy = 1'b1; resp = r;
        tick(); resp_rdy = 1'b0;
        @(negedge clk);
        check("clr_rx_rdy_in_check", 32'(clr_rx_rdy), 32'd1);
    endtask

    initial begin
        int k;
        int sends;
        logic [31:0] act, exp;

        rst = 1'b1; push = 1'b0; push_cmd = '0; cmd_sent = 1'b0; resp_rdy = 1'b0;
        resp = '0; clr_err = 1'b0; abort = 1'b0;

        // Single calibrate command.
        vq.push_back(mk(1'b1,16'h2000,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b1,4'd0,16'h0000));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd1,16'h0000));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0,4'd1,16'h0000));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,1'b1,4'd0,16'h2000));
        vq.push_back(mk(1'b0,16'h0000,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b1,4'd0,16'h2000));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b1,8'hA5, 1'b0,1'b0,1'b0,1'b1,1'b1,4'd0,16'h2000));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,1'b1,1'b1,4'd0,16'h2000));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b1,4'd0,16'h2000));
        // Three moves pushed back-to-back.
        vq.push_back(mk(1'b1,16'h4001,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b1,4'd0,16'h2000));
        vq.push_back(mk(1'b1,16'h4021,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,4'd1,16'h2000));
        vq.push_back(mk(1'b1,16'h4041,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0,4'd2,16'h2000));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,1'b0,4'd2,16'h4001));
        vq.push_back(mk(1'b0,16'h0000,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0,4'd2,16'h4001));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b1,8'hA5, 1'b0,1'b0,1'b0,1'b1,1'b0,4'd2,16'h4001));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b1,1'b0,4'd2,16'h4001));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0,4'd2,16'h4001));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,1'b0,4'd1,16'h4021));
        vq.push_back(mk(1'b0,16'h0000,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0,4'd1,16'h4021));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b1,8'hA5, 1'b0,1'b0,1'b0,1'b1,1'b0,4'd1,16'h4021));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b1,1'b0,4'd1,16'h4021));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0,4'd1,16'h4021));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,1'b1,4'd0,16'h4041));
        // resp_rdy raised early in WAIT_SENT is held and taken on entry to WAIT_RESP.
        vq.push_back(mk(1'b0,16'h0000,1'b1,1'b1,8'hA5, 1'b0,1'b0,1'b0,1'b1,1'b1,4'd0,16'h4041));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b1,8'hA5, 1'b0,1'b0,1'b0,1'b1,1'b1,4'd0,16'h4041));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,1'b1,1'b1,4'd0,16'h4041));
        vq.push_back(mk(1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b1,4'd0,16'h4041));

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_state", snap(), RstSnap);
        rst = 1'b0;

        // Table-driven cycle vectors.
        foreach (vq[i]) begin
            tick();
            push = vq[i].push; push_cmd = vq[i].pcmd; cmd_sent = vq[i].csent;
            resp_rdy = vq[i].rrdy; resp = vq[i].rsp;
            @(negedge clk);
            act = 32'({send_cmd, clr_rx_rdy, done, busy, empty, level, cmd});
            exp = 32'({vq[i].x_send, vq[i].x_clr, vq[i].x_done, vq[i].x_busy, vq[i].x_empty,
                       vq[i].x_level, vq[i].x_cmd});
            check($sformatf("vec%0d", i), act, exp);
        end

        // Overflow: first command stalled in WAIT_SENT, nine more pushed, last one dropped.
        tick(); push = 1'b1; push_cmd = 16'h4100;
        tick(); push = 1'b0;
        wait_send(16'h4100, "ovf_first");
        for (int i = 1; i <= 9; i++) begin
            tick(); push = 1'b1; push_cmd = 16'h4100 + 16'(i);
        end
        tick(); push = 1'b0;
        @(negedge clk);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(ovf), 32'd1);
        tick(); clr_err = 1'b1;
        tick(); clr_err = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(ovf), 32'd0);
        check("ovf_still_busy", 32'(busy), 32'd1);
        respond(8'hA5);
        check("ovf_no_early_done", 32'(done), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            wait_send(16'h4100 + 16'(i), $sformatf("ovf_q%0d", i));
            respond(8'hA5);
        end
        check("ovf_done", 32'(done), 32'd1);
        @(negedge clk);
        check("ovf_drained", 32'({busy, empty}), 32'b01);

        // Bad response: error retains the queue, clr_err resumes it.
        tick(); push = 1'b1; push_cmd = 16'h4001;
        tick(); push_cmd = 16'h4021;
        tick(); push_cmd = 16'h4041;
        tick(); push = 1'b0;
        for (int t = 0; t < Tries; t++) begin
            wait_send(16'h4001, $sformatf("bad_try%0d", t));
            respond(8'h5A);
        end
        @(negedge clk);
        check("bad_err", 32'({err, err_code, busy}), 32'b1010);
        check("bad_level", 32'(level), 32'd2);
        sends = 0;
        repeat (5) begin
            @(negedge clk);
            if (send_cmd) sends++;
        end
        check("bad_no_send_in_error", 32'(sends), 32'd0);
        tick(); clr_err = 1'b1;
        tick(); clr_err = 1'b0;
        @(negedge clk);
        check("bad_cleared", 32'({err, err_code}), 32'd0);
        wait_send(16'h4021, "bad_resume1");
        respond(8'hA5);
        wait_send(16'h4041, "bad_resume2");
        respond(8'hA5);
        check("bad_done", 32'(done), 32'd1);

        // Timeout: response withheld.
        tick(); push = 1'b1; push_cmd = 16'h4061;
        tick(); push = 1'b0;
        wait_send(16'h4061, "tmo");
        k = 0;
        sends = 0;
        while (!err && k < 4000) begin
            @(negedge clk);
            k++;
            if (send_cmd) sends++;
        end
        check("tmo_cycles", 32'(k), 32'(Tries * 1000));
        check("tmo_resends", 32'(sends), 32'(Tries - 1));
        check("tmo_code", 32'({err, err_code}), 32'b110);
        tick(); clr_err = 1'b1;
        tick(); clr_err = 1'b0;
        @(negedge clk);
        check("tmo_cleared_idle", 32'({busy, err, err_code}), 32'd0);

        // Abort in WAIT_RESP with four commands queued; a simultaneous push is discarded.
        for (int i = 0; i < 5; i++) begin
            tick(); push = 1'b1; push_cmd = 16'h4300 + 16'(i);
        end
        tick(); push = 1'b0;
        tick(); cmd_sent = 1'b1;
        tick(); cmd_sent = 1'b0;
        @(negedge clk);
        check("abort_pre", 32'({busy, clr_rx_rdy, level}), 32'h24);
        tick(); abort = 1'b1; push = 1'b1; push_cmd = 16'h4399;
        @(negedge clk);
        check("abort_clr_rx_rdy", 32'(clr_rx_rdy), 32'd1);
        tick(); abort = 1'b0; push = 1'b0;
        @(negedge clk);
        check("abort_flushed", 32'({busy, empty, level}), 32'h10);
        check("abort_cmd_kept", 32'(cmd), 32'h4300);
        sends = 0;
        repeat (20) begin
            @(negedge clk);
            if (send_cmd) sends++;
        end
        check("abort_no_send", 32'(sends), 32'd0);

        // Asynchronous reset in WAIT_SENT with a command still queued.
        tick(); push = 1'b1; push_cmd = 16'h4400;
        tick(); push_cmd = 16'h4401;
        tick(); push = 1'b0;
        wait_send(16'h4400, "rst");
        tick();
        #2 rst = 1'b1;
        #1 check("rst_mid_wait_sent", snap(), RstSnap);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stays_idle", snap(), RstSnap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
